// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between instruction fetch (0)
// and data load/store (1). One transaction in flight, aborted if the memory never answers.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [31:0]       addr0,
    input  logic              we0,
    input  logic [31:0]       wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic [31:0]       addr1,
    input  logic              we1,
    input  logic [31:0]       wdata1,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_sel,
    output logic [31:0]       mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_next;
    logic               mem_req_next;
    logic               mem_sel_next;
    logic               ack0_next, ack1_next;
    logic               err_next;
    logic [31:0]        rdata_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               last, last_next;
    logic               winner;
    logic               timeout_hit;

    // last starts at 1 so requester 0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_sel <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'h0;
            cnt     <= '0;
            last    <= 1'b1;
        end else begin
            state   <= state_next;
            mem_req <= mem_req_next;
            mem_sel <= mem_sel_next;
            ack0    <= ack0_next;
            ack1    <= ack1_next;
            err     <= err_next;
            rdata   <= rdata_next;
            cnt     <= cnt_next;
            last    <= last_next;
        end
    end

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_next   = state;
        mem_req_next = mem_req;
        mem_sel_next = mem_sel;
        ack0_next    = 1'b0;
        ack1_next    = 1'b0;
        err_next     = 1'b0;
        rdata_next   = rdata;
        cnt_next     = cnt;
        last_next    = last;
        winner       = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    winner       = (req0 && req1) ? ~last : req1;
                    mem_sel_next = winner;
                    mem_req_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt + 1'b1;
                // mem_ready takes priority over an abort landing in the same cycle
                if (mem_ready || timeout_hit) begin
                    ack0_next    = ~mem_sel;
                    ack1_next    = mem_sel;
                    err_next     = ~mem_ready;
                    rdata_next   = mem_ready ? mem_rdata : 32'h0;
                    mem_req_next = 1'b0;
                    last_next    = mem_sel;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_addr  = mem_sel ? addr1 : addr0;
    assign mem_wdata = mem_sel ? wdata1 : wdata0;
    assign mem_we    = mem_req & (mem_sel ? we1 : we0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with hand-written sequences
// for contention, timeout abort and reset during a transaction.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, err;
    logic [31:0] rdata;
    logic        mem_req, mem_sel, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int testCount = 0;
    int failCount = 0;

    mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        int          delay;
        logic [31:0] rdval;
        logic        expSel, expWe;
        logic [31:0] expAddr, expWdata;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        mem_ready = 0; mem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_mem_req", 32'(mem_req), 0);
        checkOutput("reset_mem_sel", 32'(mem_sel), 0);
        checkOutput("reset_acks", 32'({ack1, ack0}), 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete transaction starting from IDLE with no requests pending
    task automatic applyStimulus(input vec_t v, input int idx);
        int waited;
        string tag;
        tag = $sformatf("v%0d", idx);
        req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
        addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
        mem_ready = 0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_req && waited < 20);
        checkOutput({tag, "_grant_latency"}, 32'(waited), 1);
        checkOutput({tag, "_mem_sel"}, 32'(mem_sel), 32'(v.expSel));
        checkOutput({tag, "_mem_addr"}, mem_addr, v.expAddr);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'(v.expWe));
        checkOutput({tag, "_mem_wdata"}, mem_wdata, v.expWdata);
        for (int k = 0; k < v.delay; k++) @(negedge clk);
        mem_rdata = v.rdval;
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        mem_rdata = 32'hFFFF_FFFF;
        checkOutput({tag, "_acks"}, 32'({ack1, ack0}), v.expSel ? 32'd2 : 32'd1);
        checkOutput({tag, "_err"}, 32'(err), 0);
        checkOutput({tag, "_rdata"}, rdata, v.rdval);
        checkOutput({tag, "_idle_mem_req"}, 32'(mem_req), 0);
        checkOutput({tag, "_idle_mem_we"}, 32'(mem_we), 0);
        req0 = 0; req1 = 0;
        @(negedge clk);
        checkOutput({tag, "_ack_pulse"}, 32'({ack1, ack0}), 0);
        checkOutput({tag, "_rdata_hold"}, rdata, v.rdval);
    endtask

    vec_t vecs[7];

    initial begin
        int busy, grants, overlap, ackBusy;
        logic expSel, prevReq;

        // Starting from reset: last=1, so ties go 0,1,0,... as each grant updates last
        vecs[0] = '{1, 0, 0, 0, 32'h0040_0000, 32'h1001_0004, 32'h0, 32'h0, 3, 32'h8C08_0004, 0, 0, 32'h0040_0000, 32'h0};
        vecs[1] = '{1, 1, 0, 0, 32'h0040_0004, 32'h1001_0004, 32'h0, 32'h0, 0, 32'h1111_2222, 1, 0, 32'h1001_0004, 32'h0};
        vecs[2] = '{1, 1, 0, 0, 32'h0040_0008, 32'h1001_0008, 32'h0, 32'h0, 1, 32'h3333_4444, 0, 0, 32'h0040_0008, 32'h0};
        vecs[3] = '{0, 1, 0, 1, 32'h0040_000C, 32'h1001_0000, 32'h0, 32'hDEAD_BEEF, 2, 32'h0BAD_F00D, 1, 1, 32'h1001_0000, 32'hDEAD_BEEF};
        vecs[4] = '{1, 0, 0, 1, 32'h0040_0010, 32'h1001_0010, 32'h1234_5678, 32'h5555_AAAA, 0, 32'h0000_00FF, 0, 0, 32'h0040_0010, 32'h1234_5678};
        vecs[5] = '{1, 1, 0, 0, 32'h0040_0014, 32'h1001_0014, 32'h0, 32'h0, 15, 32'hCAFE_0005, 1, 0, 32'h1001_0014, 32'h0};
        vecs[6] = '{0, 1, 0, 0, 32'h0040_0018, 32'h1001_0018, 32'h0, 32'h0, 0, 32'h7777_0006, 1, 0, 32'h1001_0018, 32'h0};

        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        // Timeout abort: mem_ready never comes
        req0 = 1; addr0 = 32'h0040_0020; we0 = 0; mem_ready = 0;
        busy = 0;
        @(negedge clk);
        while (mem_req && busy < 40) begin
            busy++;
            @(negedge clk);
        end
        checkOutput("timeout_busy_cycles", 32'(busy), 16);
        checkOutput("timeout_acks", 32'({ack1, ack0}), 1);
        checkOutput("timeout_err", 32'(err), 1);
        checkOutput("timeout_rdata", rdata, 32'h0);
        req0 = 0;
        @(negedge clk);
        checkOutput("timeout_err_pulse", 32'(err), 0);
        applyStimulus('{1, 0, 0, 0, 32'h0040_0024, 32'h0, 32'h0, 32'h0, 1, 32'h2468_ACE0, 0, 0, 32'h0040_0024, 32'h0}, 7);

        // Continuous contention from reset: grants must alternate 0,1,0,1,...
        doReset();
        req0 = 1; req1 = 1;
        addr0 = 32'h0040_0000; addr1 = 32'h1001_0000;
        expSel = 0; prevReq = 0; grants = 0; overlap = 0; ackBusy = 0;
        for (int i = 0; i < 60 && grants < 6; i++) begin
            @(negedge clk);
            mem_ready = 0;
            if (ack0 && ack1) overlap++;
            if ((ack0 || ack1) && mem_req) ackBusy++;
            if (mem_req) begin
                if (!prevReq) begin
                    checkOutput($sformatf("rr_grant%0d_sel", grants), 32'(mem_sel), 32'(expSel));
                    expSel = ~expSel;
                    grants++;
                end
                mem_rdata = 32'(i);
                mem_ready = 1;
            end
            prevReq = mem_req;
        end
        @(negedge clk);
        mem_ready = 0;
        req0 = 0; req1 = 0;
        checkOutput("rr_grant_count", 32'(grants), 6);
        checkOutput("rr_ack_overlap", 32'(overlap), 0);
        checkOutput("rr_ack_without_idle", 32'(ackBusy), 0);
        @(negedge clk);
        @(negedge clk);

        // Reset while BUSY with requester 1 owning the port
        req1 = 1; addr1 = 32'h1001_0040;
        @(negedge clk);
        checkOutput("rst_mid_pre_sel", 32'(mem_sel), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_mem_req", 32'(mem_req), 0);
        checkOutput("rst_mid_mem_sel", 32'(mem_sel), 0);
        checkOutput("rst_mid_rdata", rdata, 32'h0);
        checkOutput("rst_mid_err_acks", 32'({err, ack1, ack0}), 0);
        req0 = 1; req1 = 1;
        @(negedge clk);
        checkOutput("rst_mid_no_ack", 32'({ack1, ack0}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_regrant_req", 32'(mem_req), 1);
        checkOutput("rst_mid_tie_sel", 32'(mem_sel), 0);
        req0 = 0; req1 = 0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
